// File: rtl/sum_accumulator.sv
// sum_accumulator: block-wise accumulation of 16-bit two's-complement samples
// around an external 16-bit adder. Every SAMPLE_COUNT accepted samples it
// presents the total and the overflow statistics downstream.
module sum_accumulator #(
   parameter int SAMPLE_COUNT = 8,   // samples per block, 2..255
   parameter bit SATURATE     = 1'b0 // 1: clamp total on overflow, 0: wrap
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [15:0] in_data,
   output logic [15:0] add_a,
   output logic [15:0] add_b,
   output logic        add_carry_in,
   input  logic [15:0] add_sum,
   input  logic        add_overflow,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [15:0] out_sum,
   output logic        out_ovf,
   output logic [7:0]  out_ovf_count
);

   // Counter value held while the final sample of a block is being accepted.
   localparam logic [7:0] LAST_IDX = 8'(SAMPLE_COUNT - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACCUM = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t      state_reg, state_next;
   logic [15:0] acc_reg, acc_next;
   logic [7:0]  cnt_reg, cnt_next;
   logic        ovf_reg, ovf_next;
   logic [7:0]  ovf_cnt_reg, ovf_cnt_next;

   logic [15:0] clamp_value;
   logic        take;

   // Saturation limit follows the sign of the incoming sample: a positive
   // sample can only overflow upward (7FFF), a negative one downward (8000).
   genvar gi;
   generate
      for (gi = 0; gi < 16; gi++) begin : g_clamp
         if (gi == 15) begin : g_sign
            assign clamp_value[gi] = in_data[15];
         end else begin : g_mag
            assign clamp_value[gi] = ~in_data[15];
         end
      end
   endgenerate

   // Handshake decode uses registered state only, so in_ready never depends on in_valid.
   assign take          = (state_reg == ACCUM) && in_valid;
   assign in_ready      = (state_reg == ACCUM);
   assign out_valid     = (state_reg == DONE);
   assign add_a         = acc_reg;
   assign add_b         = in_data;
   assign add_carry_in  = 1'b0;
   assign out_sum       = acc_reg;
   assign out_ovf       = ovf_reg;
   assign out_ovf_count = ovf_cnt_reg;

   // State register with synchronous reset; reset discards any partial block.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg   <= IDLE;
         acc_reg     <= 16'h0000;
         cnt_reg     <= 8'h00;
         ovf_reg     <= 1'b0;
         ovf_cnt_reg <= 8'h00;
      end else begin
         state_reg   <= state_next;
         acc_reg     <= acc_next;
         cnt_reg     <= cnt_next;
         ovf_reg     <= ovf_next;
         ovf_cnt_reg <= ovf_cnt_next;
      end
   end

   // Next-state logic: everything holds unless a start, a sample or a consumer take occurs.
   always_comb begin
      state_next   = state_reg;
      acc_next     = acc_reg;
      cnt_next     = cnt_reg;
      ovf_next     = ovf_reg;
      ovf_cnt_next = ovf_cnt_reg;
      case (state_reg)
         IDLE: begin
            if (start) begin
               acc_next     = 16'h0000;
               cnt_next     = 8'h00;
               ovf_next     = 1'b0;
               ovf_cnt_next = 8'h00;
               state_next   = ACCUM;
            end
         end
         ACCUM: begin
            if (take) begin
               if (SATURATE && add_overflow) begin
                  acc_next = clamp_value;
               end else begin
                  acc_next = add_sum;
               end
               cnt_next = cnt_reg + 8'h01;
               if (add_overflow) begin
                  ovf_next = 1'b1;
                  if (ovf_cnt_reg != 8'hFF) begin
                     ovf_cnt_next = ovf_cnt_reg + 8'h01;
                  end
               end
               if (cnt_reg == LAST_IDX) begin
                  state_next = DONE;
               end
            end
         end
         DONE: begin
            if (out_ready) begin
               state_next = IDLE;
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_sum_accumulator.sv
// tb_sum_accumulator: drives a wrapping and a saturating instance with the same
// stimulus, supplies the external adder, and checks both against a block-level
// arithmetic model every cycle plus hand-computed block results.
module tb_sum_accumulator;

   localparam int N = 8;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic        in_valid;
   logic [15:0] in_data;
   logic        out_ready;

   logic [1:0]  in_ready;
   logic [15:0] add_a [2];
   logic [15:0] add_b [2];
   logic [1:0]  add_carry_in;
   logic [15:0] add_sum [2];
   logic [1:0]  add_overflow;
   logic [1:0]  out_valid;
   logic [15:0] out_sum [2];
   logic [1:0]  out_ovf;
   logic [7:0]  out_ovf_count [2];

   int n_tests = 0;
   int n_fail  = 0;
   bit chk_en  = 1'b0;

   logic [15:0] samp [N];

   always #5 clk = ~clk;

   // Instance 0 wraps, instance 1 saturates; each has its own external adder.
   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_dut
         assign add_sum[gi]      = add_a[gi] + add_b[gi];
         assign add_overflow[gi] = (add_a[gi][15] == add_b[gi][15]) &&
                                   (add_sum[gi][15] != add_a[gi][15]);
         sum_accumulator #(
            .SAMPLE_COUNT(N),
            .SATURATE    (gi == 1)
         ) u_dut (
            .clk          (clk),
            .rst          (rst),
            .start        (start),
            .in_valid     (in_valid),
            .in_ready     (in_ready[gi]),
            .in_data      (in_data),
            .add_a        (add_a[gi]),
            .add_b        (add_b[gi]),
            .add_carry_in (add_carry_in[gi]),
            .add_sum      (add_sum[gi]),
            .add_overflow (add_overflow[gi]),
            .out_valid    (out_valid[gi]),
            .out_ready    (out_ready),
            .out_sum      (out_sum[gi]),
            .out_ovf      (out_ovf[gi]),
            .out_ovf_count(out_ovf_count[gi])
         );
      end
   endgenerate

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // ---------------- behavioural model ----------------
   // Signed overflow decided from exact integer arithmetic.
   function automatic bit f_ov(input logic [15:0] tot, input logic [15:0] x);
      int ex;
      ex = int'($signed(tot)) + int'($signed(x));
      return (ex > 32767) || (ex < -32768);
   endfunction

   function automatic logic [15:0] f_next(input logic [15:0] tot, input logic [15:0] x, input bit sat);
      int ex;
      ex = int'($signed(tot)) + int'($signed(x));
      if (sat && ((ex > 32767) || (ex < -32768))) return (ex > 0) ? 16'h7FFF : 16'h8000;
      return 16'(ex);
   endfunction

   int          m_phase = 0;  // 0 idle, 1 collecting, 2 result offered
   int          m_n     = 0;
   logic [15:0] m_total [2];
   logic        m_ovf   [2];
   int          m_ocnt  [2];

   always @(posedge clk) begin
      if (rst) begin
         m_phase <= 0;
         m_n     <= 0;
         for (int k = 0; k < 2; k++) begin
            m_total[k] <= 16'h0000;
            m_ovf[k]   <= 1'b0;
            m_ocnt[k]  <= 0;
         end
      end else if (m_phase == 0) begin
         if (start) begin
            m_phase <= 1;
            m_n     <= 0;
            for (int k = 0; k < 2; k++) begin
               m_total[k] <= 16'h0000;
               m_ovf[k]   <= 1'b0;
               m_ocnt[k]  <= 0;
            end
         end
      end else if (m_phase == 1) begin
         if (in_valid) begin
            for (int k = 0; k < 2; k++) begin
               m_total[k] <= f_next(m_total[k], in_data, k == 1);
               if (f_ov(m_total[k], in_data)) begin
                  m_ovf[k]  <= 1'b1;
                  m_ocnt[k] <= (m_ocnt[k] < 255) ? m_ocnt[k] + 1 : 255;
               end
            end
            m_n <= m_n + 1;
            if (m_n + 1 == N) m_phase <= 2;
         end
      end else begin
         if (out_ready) m_phase <= 0;
      end
   end

   // Per-cycle comparison of both instances against the model.
   always @(negedge clk) begin
      if (chk_en) begin
         for (int k = 0; k < 2; k++) begin
            check($sformatf("in_ready[%0d]", k),  32'(in_ready[k]),  32'(m_phase == 1));
            check($sformatf("out_valid[%0d]", k), 32'(out_valid[k]), 32'(m_phase == 2));
            check($sformatf("out_sum[%0d]", k),   32'(out_sum[k]),   32'(m_total[k]));
            check($sformatf("add_a[%0d]", k),     32'(add_a[k]),     32'(m_total[k]));
            check($sformatf("add_b[%0d]", k),     32'(add_b[k]),     32'(in_data));
            check($sformatf("carry_in[%0d]", k),  32'(add_carry_in[k]), 32'd0);
            check($sformatf("out_ovf[%0d]", k),   32'(out_ovf[k]),   32'(m_ovf[k]));
            check($sformatf("ovf_count[%0d]", k), 32'(out_ovf_count[k]), 32'(m_ocnt[k]));
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   // Offers samples 0..n-1 from samp; optional random idle cycles and a
   // start pulse raised while collecting.
   task automatic feed(input int n, input bit gaps, input bit start_mid);
      int i = 0;
      int guard = 0;
      while (i < n && guard < 200) begin
         in_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
         in_data  = in_valid ? samp[i] : 16'($urandom);
         start    = start_mid && (i == 3);
         if (in_valid && in_ready[0]) i++;
         tick();
         guard++;
      end
      in_valid = 1'b0;
      start    = 1'b0;
      check("feed_budget", 32'(i), 32'(n));
   endtask

   task automatic wait_done();
      int cyc = 0;
      while (out_valid[0] !== 1'b1 && cyc < 20) begin
         tick();
         cyc++;
      end
      check("done_seen", 32'(out_valid[0]), 32'd1);
   endtask

   task automatic release_result();
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      check("idle_after_take", 32'(out_valid[0]), 32'd0);
   endtask

   task automatic fill(input logic [15:0] v);
      for (int i = 0; i < N; i++) samp[i] = v;
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = 16'h0000; out_ready = 1'b0;
      tick();
      tick();
      rst = 1'b0;
      chk_en = 1'b1;
      check("rst_in_ready",  32'(in_ready[0]),  32'd0);
      check("rst_out_valid", 32'(out_valid[0]), 32'd0);
      check("rst_out_sum",   32'(out_sum[0]),   32'h0000);
      check("rst_ovf_count", 32'(out_ovf_count[1]), 32'h00);

      // Block of ones at full rate: result visible right after the 8th accepting edge.
      fill(16'h0001);
      pulse_start();
      feed(N - 1, 1'b0, 1'b0);
      check("lat_not_early", 32'(out_valid[0]), 32'd0);
      feed(1, 1'b0, 1'b0);
      samp[0] = 16'h0001;
      check("lat_valid",  32'(out_valid[0]), 32'd1);
      check("ones_sum0",  32'(out_sum[0]), 32'h0008);
      check("ones_sum1",  32'(out_sum[1]), 32'h0008);
      check("ones_ovf",   32'(out_ovf[0]), 32'd0);
      check("ones_cnt",   32'(out_ovf_count[0]), 32'd0);
      release_result();
      tick();
      check("hold_in_idle", 32'(out_sum[0]), 32'h0008);

      // 0x7000 x8: wrapping crosses the limit 4 times; saturating clamps 7 times.
      fill(16'h7000);
      pulse_start();
      feed(N, 1'b0, 1'b0);
      wait_done();
      check("wrap_sum",   32'(out_sum[0]), 32'h8000);
      check("wrap_ovf",   32'(out_ovf[0]), 32'd1);
      check("wrap_cnt",   32'(out_ovf_count[0]), 32'd4);
      check("sat_sum",    32'(out_sum[1]), 32'h7FFF);
      check("sat_ovf",    32'(out_ovf[1]), 32'd1);
      check("sat_cnt",    32'(out_ovf_count[1]), 32'd7);
      release_result();

      // Samples 1..8 with random in_valid, result held 5 cycles before taken.
      for (int i = 0; i < N; i++) samp[i] = 16'(i + 1);
      pulse_start();
      feed(N, 1'b1, 1'b0);
      wait_done();
      for (int c = 0; c < 5; c++) begin
         tick();
         check("hold_valid", 32'(out_valid[0]), 32'd1);
         check("hold_sum",   32'(out_sum[0]),   32'h0024);
      end
      release_result();
      check("idle_ready", 32'(in_ready[0]), 32'd0);

      // Abort after 3 samples, then a clean block of -1 x8.
      fill(16'h1234);
      pulse_start();
      feed(3, 1'b0, 1'b0);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("abort_ready", 32'(in_ready[0]), 32'd0);
      check("abort_sum",   32'(out_sum[0]),  32'h0000);
      fill(16'hFFFF);
      pulse_start();
      feed(N, 1'b0, 1'b0);
      wait_done();
      check("neg_sum0", 32'(out_sum[0]), 32'hFFF8);
      check("neg_sum1", 32'(out_sum[1]), 32'hFFF8);
      check("neg_ovf",  32'(out_ovf[0]), 32'd0);
      release_result();

      // rst and start together: stays idle.
      rst = 1'b1; start = 1'b1;
      tick();
      rst = 1'b0; start = 1'b0;
      tick();
      check("rst_wins", 32'(in_ready[0]), 32'd0);

      // start raised mid-block and while the result waits: both ignored.
      fill(16'h0100);
      pulse_start();
      feed(N, 1'b1, 1'b1);
      wait_done();
      start = 1'b1;
      tick();
      tick();
      start = 1'b0;
      check("start_in_done_valid", 32'(out_valid[0]), 32'd1);
      check("start_ign_sum",       32'(out_sum[0]),   32'h0800);
      release_result();
      tick();

      chk_en = 1'b0;
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1, "watchdog");
   end

endmodule
